vectored_interrupt_controller: RTL and testbench

VECTORED_INTERRUPT_CONTROLLER -- requirements
Module: vectored_interrupt_controller

---
 rtl/vectored_interrupt_controller.sv | 98 +++++++++
 tb/tb_vectored_interrupt_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller: fixed-priority dispatch with edge/level
// channels, single-level service and return-from-interrupt handling.
module vectored_interrupt_controller #(
    parameter int                   NUM_IRQ       = 8,
    parameter int                   PC_WIDTH      = 11,
    parameter logic [PC_WIDTH-1:0]  VECTOR_BASE   = 11'h7F0,
    parameter int                   VECTOR_STRIDE = 1
) (
    input  logic                instr_clock,
    input  logic                reset_bar,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  irq_enable,
    input  logic [NUM_IRQ-1:0]  irq_edge_mode,
    input  logic                gie,
    input  logic [NUM_IRQ-1:0]  clear_pending,
    input  logic [1:0]          pc_mux_control,
    input  logic [PC_WIDTH-1:0] pc_next,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_save,
    output logic                int_active,
    output logic [3:0]          int_id,
    output logic [NUM_IRQ-1:0]  pending
);

    typedef enum logic {
        IDLE,
        IN_SERVICE
    } state_t;

    state_t              state;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  edge_pend;
    logic [NUM_IRQ-1:0]  edge_nxt;
    logic [NUM_IRQ-1:0]  cand;
    logic [NUM_IRQ-1:0]  disp_mask;
    logic [3:0]          winner;
    logic                is_return;
    logic                dispatch;
    logic [PC_WIDTH-1:0] vector;

    assign pending = (edge_pend & irq_edge_mode) | (irq_in & ~irq_edge_mode);
    assign cand    = pending & irq_enable;
    assign is_return = (pc_mux_control == 2'b11);

    // Scan from the top so the lowest-index candidate wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) winner = 4'(i);
        end
    end

    assign dispatch = reset_bar && (state == IDLE) && gie
                      && (|cand) && !is_return;

    always_comb begin
        disp_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            disp_mask[i] = dispatch && (winner == 4'(i));
        end
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    assign edge_nxt = (edge_pend & ~clear_pending & ~disp_mask)
                    | (irq_in & ~irq_q & irq_edge_mode);

    assign vector = VECTOR_BASE
                  + PC_WIDTH'(winner) * PC_WIDTH'(VECTOR_STRIDE);

    assign pc_out     = dispatch ? vector : pc_next;
    assign int_active = (state == IN_SERVICE);

    always_ff @(posedge instr_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state     <= IDLE;
            pc_save   <= '0;
            int_id    <= '0;
            irq_q     <= '0;
            edge_pend <= '0;
        end else begin
            irq_q     <= irq_in;
            edge_pend <= edge_nxt;
            unique case (state)
                IDLE: begin
                    if (dispatch) begin
                        pc_save <= pc_next;
                        int_id  <= winner;
                        state   <= IN_SERVICE;
                    end
                end
                IN_SERVICE: begin
                    if (is_return) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed self-checking bench for vectored_interrupt_controller,
// including a second instance with a wrapping vector table.
module tb_vectored_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset_bar;
    logic [7:0]  irq_in;
    logic [7:0]  irq_enable;
    logic [7:0]  irq_edge_mode;
    logic        gie;
    logic [7:0]  clear_pending;
    logic [1:0]  pc_mux_control;
    logic [10:0] pc_next;
    logic [10:0] pc_out;
    logic [10:0] pc_save;
    logic        int_active;
    logic [3:0]  int_id;
    logic [7:0]  pending;
    logic [10:0] pc_out2;
    logic [10:0] pc_save2;
    logic        int_active2;
    logic [3:0]  int_id2;
    logic [7:0]  pending2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vectored_interrupt_controller dut (
        .instr_clock    (clk),
        .reset_bar      (reset_bar),
        .irq_in         (irq_in),
        .irq_enable     (irq_enable),
        .irq_edge_mode  (irq_edge_mode),
        .gie            (gie),
        .clear_pending  (clear_pending),
        .pc_mux_control (pc_mux_control),
        .pc_next        (pc_next),
        .pc_out         (pc_out),
        .pc_save        (pc_save),
        .int_active     (int_active),
        .int_id         (int_id),
        .pending        (pending)
    );

    vectored_interrupt_controller #(
        .VECTOR_BASE   (11'h7FE),
        .VECTOR_STRIDE (2)
    ) dut2 (
        .instr_clock    (clk),
        .reset_bar      (reset_bar),
        .irq_in         (irq_in),
        .irq_enable     (irq_enable),
        .irq_edge_mode  (irq_edge_mode),
        .gie            (gie),
        .clear_pending  (clear_pending),
        .pc_mux_control (pc_mux_control),
        .pc_next        (pc_next),
        .pc_out         (pc_out2),
        .pc_save        (pc_save2),
        .int_active     (int_active2),
        .int_id         (int_id2),
        .pending        (pending2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_bar      = 1'b0;
        irq_in         = 8'h00;
        irq_enable     = 8'hFF;
        irq_edge_mode  = 8'hFD;
        gie            = 1'b1;
        clear_pending  = 8'h00;
        pc_mux_control = 2'b00;
        pc_next        = 11'h045;
        #2;
        irq_in = 8'h02;
        #1;
        check("rst_pc_out", 32'(pc_out), 32'h045);
        check("rst_pending_level", 32'(pending), 32'h02);
        check("rst_int_active", 32'(int_active), 32'h0);
        check("rst_pc_save", 32'(pc_save), 32'h0);
        check("rst_int_id", 32'(int_id), 32'h0);
        irq_in = 8'h00;
        step();
        step();
        reset_bar = 1'b1;
        step();

        // Edge channel 3 dispatch
        irq_in = 8'h08;
        #1;
        check("e3_no_pend_yet", 32'(pending), 32'h00);
        check("e3_pc_out_pre", 32'(pc_out), 32'h045);
        step();
        check("e3_pending", 32'(pending), 32'h08);
        check("e3_vector", 32'(pc_out), 32'h7F3);
        check("e3_vector_wrap2", 32'(pc_out2), 32'h004);
        step();
        check("e3_active", 32'(int_active), 32'h1);
        check("e3_pc_save", 32'(pc_save), 32'h045);
        check("e3_int_id", 32'(int_id), 32'h3);
        check("e3_pend_clr", 32'(pending), 32'h00);
        check("e3_pc_out_svc", 32'(pc_out), 32'h045);
        irq_in = 8'h00;
        pc_mux_control = 2'b11;
        pc_next = 11'h046;
        #1;
        check("ret_pc_out", 32'(pc_out), 32'h046);
        step();
        check("ret_inactive", 32'(int_active), 32'h0);
        check("ret_pc_save_kept", 32'(pc_save), 32'h045);
        pc_mux_control = 2'b00;

        // Level ch1 and edge ch5 together
        irq_in = 8'h22;
        #1;
        check("pri_vector_ch1", 32'(pc_out), 32'h7F1);
        check("pri_wrap_ch1", 32'(pc_out2), 32'h000);
        step();
        check("pri_int_id1", 32'(int_id), 32'h1);
        check("pri_pending", 32'(pending), 32'h22);
        irq_in = 8'h20;
        pc_mux_control = 2'b11;
        #1;
        check("pri_ret_pc_out", 32'(pc_out), 32'h046);
        step();
        pc_mux_control = 2'b00;
        #1;
        check("pri_vector_ch5", 32'(pc_out), 32'h7F5);
        step();
        check("pri_int_id5", 32'(int_id), 32'h5);
        check("pri_pend_clr", 32'(pending), 32'h00);
        irq_in = 8'h00;
        pc_mux_control = 2'b11;
        step();
        pc_mux_control = 2'b00;

        // Return with ch2 pending, then IDLE return ignored
        irq_in = 8'h08;
        step();
        step();
        check("r2_in_svc", 32'(int_id), 32'h3);
        irq_in = 8'h04;
        step();
        check("r2_pending", 32'(pending), 32'h04);
        pc_mux_control = 2'b11;
        #1;
        check("r2_ret_pc_out", 32'(pc_out), 32'h046);
        check("r2_active_pre", 32'(int_active), 32'h1);
        step();
        check("r2_active_fall", 32'(int_active), 32'h0);
        check("idle_ret_pc_out", 32'(pc_out), 32'h046);
        step();
        check("idle_ret_no_disp", 32'(int_active), 32'h0);
        pc_mux_control = 2'b00;
        #1;
        check("r2_vector", 32'(pc_out), 32'h7F2);
        step();
        check("r2_int_id", 32'(int_id), 32'h2);
        irq_in = 8'h00;
        pc_mux_control = 2'b11;
        step();
        pc_mux_control = 2'b00;

        // Disabled ch0 stays pending until enabled
        irq_enable = 8'hFE;
        irq_in = 8'h01;
        step();
        check("dis_pending", 32'(pending), 32'h01);
        check("dis_pc_out", 32'(pc_out), 32'h046);
        step();
        check("dis_inactive", 32'(int_active), 32'h0);
        irq_enable = 8'hFF;
        #1;
        check("en_vector", 32'(pc_out), 32'h7F0);
        step();
        check("en_int_id", 32'(int_id), 32'h0);
        irq_in = 8'h00;
        pc_mux_control = 2'b11;
        step();
        pc_mux_control = 2'b00;

        // clear_pending and set-over-clear with gie off
        gie = 1'b0;
        irq_in = 8'h40;
        step();
        check("gie_off_pending", 32'(pending), 32'h40);
        check("gie_off_pc_out", 32'(pc_out), 32'h046);
        irq_in = 8'h00;
        clear_pending = 8'h40;
        step();
        check("clr_pending", 32'(pending), 32'h00);
        irq_in = 8'h40;
        step();
        check("set_wins_clr", 32'(pending), 32'h40);
        irq_in = 8'h00;
        step();
        clear_pending = 8'h00;
        gie = 1'b1;

        // Service ch7, accumulate 0x0C, gie drop, async reset
        irq_in = 8'h80;
        step();
        check("r7_vector", 32'(pc_out), 32'h7F7);
        step();
        check("r7_int_id", 32'(int_id), 32'h7);
        irq_in = 8'h0C;
        step();
        check("r7_pending", 32'(pending), 32'h0C);
        check("nonest_pc_out", 32'(pc_out), 32'h046);
        irq_in = 8'h00;
        gie = 1'b0;
        step();
        check("gie_drop_active", 32'(int_active), 32'h1);
        #1;
        reset_bar = 1'b0;
        #1;
        check("arst_active", 32'(int_active), 32'h0);
        check("arst_pending", 32'(pending), 32'h00);
        check("arst_pc_save", 32'(pc_save), 32'h000);
        check("arst_int_id", 32'(int_id), 32'h0);

        // Input held high through reset counts as an edge
        irq_in = 8'h10;
        step();
        reset_bar = 1'b1;
        #1;
        check("post_rst_no_pend", 32'(pending), 32'h00);
        step();
        check("post_rst_edge", 32'(pending), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
